// File: rtl/spi_regs_if.sv
// spi_regs_if: register-bus signals between an SPI front end and spi_regs.
//
// Strobe semantics (there is no backpressure on this bus):
//   we   - one-clk write strobe, synchronous to clk; wdat/addr are valid
//          while it is high and the write always completes in that cycle.
//   re   - read strobe coming from the SPI clock domain, asynchronous to clk;
//          only its rising edge matters, and addr is held stable from that
//          edge to the end of the transfer.
//   rdat - registered read data for the current addr, one clk behind addr.
interface spi_regs_if #(
  parameter int asz = 7,
  parameter int dsz = 32
);
  logic           we;
  logic           re;
  logic [dsz-1:0] wdat;
  logic [asz-1:0] addr;
  logic [dsz-1:0] rdat;

  modport master (output we, re, wdat, addr, input rdat);
  modport slave  (input we, re, wdat, addr, output rdat);
endinterface

// File: rtl/spi_regs.sv
// spi_regs: small register file behind an SPI slave, with a sample FIFO.
// Map: 0x00 ID, 0x01 CTRL (bit0 FIFO enable, bit1 self-clearing flush),
// 0x02 FREQ, 0x03 STATUS, 0x04 FIFODATA (read pops), 0x05 CYCLES.
// Optional feature: define RXADC_CYCLE_COUNTER_EN to build the free-running
// cycle counter at 0x05; without it 0x05 reads 0 and no counter exists.
module spi_regs #(
  parameter int asz     = 7,
  parameter int dsz     = 32,
  parameter int FIFO_AW = 4
) (
  input  logic           clk,
  input  logic           reset,
  spi_regs_if.slave      bus,
  input  logic           samp_valid,
  input  logic [dsz-1:0] samp_data,
  output logic [dsz-1:0] ctrl,
  output logic [dsz-1:0] freq
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_LVL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [asz-1:0]     A_ID     = asz'(0);
  localparam logic [asz-1:0]     A_CTRL   = asz'(1);
  localparam logic [asz-1:0]     A_FREQ   = asz'(2);
  localparam logic [asz-1:0]     A_STATUS = asz'(3);
  localparam logic [asz-1:0]     A_FIFO   = asz'(4);
  localparam logic [asz-1:0]     A_CYCLES = asz'(5);
  localparam logic [dsz-1:0]     ID_VAL   = dsz'(32'h52584144);

  // re synchronizer and edge-detect history
  logic re_s1_q, re_s1_d;
  logic re_s2_q, re_s2_d;
  logic re_s3_q, re_s3_d;

  // FIFO state
  logic [dsz-1:0]     mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ovf_q, ovf_d;

  // registers
  logic [dsz-1:0] ctrl_q, ctrl_d;
  logic [dsz-1:0] freq_q, freq_d;
  logic [dsz-1:0] rdat_q, rdat_d;

`ifdef RXADC_CYCLE_COUNTER_EN
  logic [31:0] cycles_q, cycles_d;
`endif

  // decoded controls
  logic           rd_pulse;
  logic           empty;
  logic           full;
  logic           wr_ctrl;
  logic           flush;
  logic           push_req;
  logic           push;
  logic           pop;
  logic           ovf_set;
  logic           ovf_clr;
  logic [dsz-1:0] status;
  logic [dsz-1:0] head;

  // Decode strobes and compute the next FIFO, register and read-data state.
  always_comb begin
    rd_pulse = re_s2_q & ~re_s3_q;
    empty    = (level_q == '0);
    full     = (level_q == FULL_LVL);
    wr_ctrl  = bus.we && (bus.addr == A_CTRL);
    flush    = wr_ctrl && bus.wdat[1];
    push_req = samp_valid && ctrl_q[0];
    // Flush wins over everything in the same cycle, so it masks push and pop.
    pop      = rd_pulse && (bus.addr == A_FIFO) && !empty && !flush;
    push     = push_req && (!full || pop) && !flush;
    ovf_set  = push_req && full && !pop && !flush;
    ovf_clr  = bus.we && (bus.addr == A_STATUS) && bus.wdat[18];

    re_s1_d = bus.re;
    re_s2_d = re_s1_q;
    re_s3_d = re_s2_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      if (push && !pop)      level_d = level_q + (FIFO_AW + 1)'(1);
      else if (pop && !push) level_d = level_q - (FIFO_AW + 1)'(1);
    end

    // A same-cycle overflow outranks a write-1-to-clear.
    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    // Flush bit is never stored, so CTRL reads it back as 0.
    ctrl_d = wr_ctrl ? (bus.wdat & ~dsz'(2)) : ctrl_q;
    freq_d = (bus.we && (bus.addr == A_FREQ)) ? bus.wdat : freq_q;

`ifdef RXADC_CYCLE_COUNTER_EN
    cycles_d = cycles_q + 32'd1;
`endif

    status              = '0;
    status[FIFO_AW:0]   = level_q;
    status[16]          = empty;
    status[17]          = full;
    status[18]          = ovf_q;

    head = empty ? '0 : mem_q[rd_ptr_q];

    rdat_d = '0;
    case (bus.addr)
      A_ID:     rdat_d = ID_VAL;
      A_CTRL:   rdat_d = ctrl_q;
      A_FREQ:   rdat_d = freq_q;
      A_STATUS: rdat_d = status;
      A_FIFO:   rdat_d = head;
`ifdef RXADC_CYCLE_COUNTER_EN
      A_CYCLES: rdat_d = dsz'(cycles_q);
`endif
      default:  rdat_d = '0;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      re_s1_q  <= 1'b0;
      re_s2_q  <= 1'b0;
      re_s3_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      ctrl_q   <= '0;
      freq_q   <= '0;
      rdat_q   <= '0;
`ifdef RXADC_CYCLE_COUNTER_EN
      cycles_q <= '0;
`endif
    end else begin
      re_s1_q  <= re_s1_d;
      re_s2_q  <= re_s2_d;
      re_s3_q  <= re_s3_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      ctrl_q   <= ctrl_d;
      freq_q   <= freq_d;
      rdat_q   <= rdat_d;
`ifdef RXADC_CYCLE_COUNTER_EN
      cycles_q <= cycles_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= samp_data;
  end

  assign bus.rdat = rdat_q;
  assign ctrl     = ctrl_q;
  assign freq     = freq_q;

endmodule

// File: tb/tb_spi_regs.sv
// tb_spi_regs: directed register table, FIFO corner sequences and a random
// run against a queue-based model of the register map.
module tb_spi_regs;

  localparam logic [31:0] ID_VAL = 32'h52584144;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        samp_valid;
  logic [31:0] samp_data;
  logic [31:0] ctrl;
  logic [31:0] freq;

  always #5 clk = ~clk;

  spi_regs_if #(.asz(7), .dsz(32)) bus ();

  spi_regs #(.asz(7), .dsz(32), .FIFO_AW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .samp_valid (samp_valid),
    .samp_data  (samp_data),
    .ctrl       (ctrl),
    .freq       (freq)
  );

  // ---------------- scoreboard / model ----------------
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_ctrl, m_freq, m_rdat, m_cyc;
  logic        m_ovf;
  logic        re_h1, re_h2, re_h3;  // re sampled 1, 2, 3 edges ago

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ctrl = '0; m_freq = '0; m_rdat = '0; m_cyc = '0; m_ovf = 1'b0;
    re_h1 = 1'b0; re_h2 = 1'b0; re_h3 = 1'b0;
  endtask

  // One clock edge of the register map, from the inputs currently applied.
  task automatic model_edge();
    logic [31:0] st;
    logic        pulse, flush, pop, push, set_ovf;
    int          n;
    n  = exp_q.size();
    st = '0;
    st[4:0] = 5'(n);
    st[16]  = (n == 0);
    st[17]  = (n == 16);
    st[18]  = m_ovf;
    case (bus.addr)
      7'h00:   m_rdat = ID_VAL;
      7'h01:   m_rdat = m_ctrl;
      7'h02:   m_rdat = m_freq;
      7'h03:   m_rdat = st;
      7'h04:   m_rdat = (n == 0) ? 32'h0 : exp_q[0];
`ifdef RXADC_CYCLE_COUNTER_EN
      7'h05:   m_rdat = m_cyc;
`endif
      default: m_rdat = 32'h0;
    endcase
    // A read request is a rising edge of re, seen two edges late.
    pulse   = re_h2 & ~re_h3;
    flush   = bus.we && (bus.addr == 7'h01) && bus.wdat[1];
    pop     = pulse && (bus.addr == 7'h04) && (n > 0);
    push    = samp_valid && m_ctrl[0];
    set_ovf = 1'b0;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (push && n == 16 && !pop) set_ovf = 1'b1;
      if (pop) void'(exp_q.pop_front());
      if (push && !set_ovf) exp_q.push_back(samp_data);
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (bus.we && bus.addr == 7'h03 && bus.wdat[18]) m_ovf = 1'b0;
    if (bus.we && bus.addr == 7'h01) m_ctrl = bus.wdat & ~32'h2;
    if (bus.we && bus.addr == 7'h02) m_freq = bus.wdat;
    re_h3 = re_h2; re_h2 = re_h1; re_h1 = bus.re;
    m_cyc = m_cyc + 32'd1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.we = 1'b0; bus.re = 1'b0; bus.wdat = '0; bus.addr = '0;
    samp_valid = 1'b0; samp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdat = d; bus.we = 1'b1;
    step();
    bus.we = 1'b0; bus.wdat = '0;
  endtask

  task automatic push_words(input int first, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      samp_valid = 1'b1; samp_data = 32'(first + i);
      step();
    end
    samp_valid = 1'b0;
  endtask

  // Rising edge on re with addr=0x04; pop lands on the third edge.
  task automatic pop_pulse();
    bus.addr = 7'h04;
    bus.re = 1'b1;
    step(); step(); step();
    bus.re = 1'b0;
    step(); step();
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    bus.addr = 7'h03;
    step();
    chk(name, bus.rdat, exp);
  endtask

  // ---------------- directed register table ----------------
  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdat;
    logic [31:0] exp_rdat;
    logic [31:0] exp_ctrl;
    logic [31:0] exp_freq;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] r1, r2;
    int          sel;
    logic [6:0]  a;
    logic [31:0] wd;

    vecs[0]  = '{1'b0, 7'h00, 32'h0,        ID_VAL,       32'h0,  32'h0};
    vecs[1]  = '{1'b0, 7'h01, 32'h0,        32'h0,        32'h0,  32'h0};
    vecs[2]  = '{1'b1, 7'h02, 32'h12345678, 32'h0,        32'h0,  32'h12345678};
    vecs[3]  = '{1'b0, 7'h02, 32'h0,        32'h12345678, 32'h0,  32'h12345678};
    vecs[4]  = '{1'b1, 7'h00, 32'hFFFFFFFF, ID_VAL,       32'h0,  32'h12345678};
    vecs[5]  = '{1'b0, 7'h00, 32'h0,        ID_VAL,       32'h0,  32'h12345678};
    vecs[6]  = '{1'b1, 7'h07, 32'h0000AAAA, 32'h0,        32'h0,  32'h12345678};
    vecs[7]  = '{1'b0, 7'h07, 32'h0,        32'h0,        32'h0,  32'h12345678};
    vecs[8]  = '{1'b0, 7'h7F, 32'h0,        32'h0,        32'h0,  32'h12345678};
    vecs[9]  = '{1'b0, 7'h03, 32'h0,        32'h00010000, 32'h0,  32'h12345678};
    vecs[10] = '{1'b0, 7'h04, 32'h0,        32'h0,        32'h0,  32'h12345678};
    vecs[11] = '{1'b1, 7'h01, 32'h000000F2, 32'h0,        32'hF0, 32'h12345678};
    vecs[12] = '{1'b0, 7'h01, 32'h0,        32'hF0,       32'hF0, 32'h12345678};
    vecs[13] = '{1'b1, 7'h01, 32'h00000002, 32'hF0,       32'h0,  32'h12345678};
    vecs[14] = '{1'b0, 7'h01, 32'h0,        32'h0,        32'h0,  32'h12345678};

    // Reset state
    do_reset();
    chk("reset_rdat", bus.rdat, 32'h0);
    chk("reset_ctrl", ctrl, 32'h0);
    chk("reset_freq", freq, 32'h0);

    // Register table
    for (int i = 0; i < 15; i++) begin
      bus.we = vecs[i].we; bus.addr = vecs[i].addr; bus.wdat = vecs[i].wdat;
      step();
      bus.we = 1'b0;
      chk($sformatf("vec%0d_rdat", i), bus.rdat, vecs[i].exp_rdat);
      chk($sformatf("vec%0d_ctrl", i), ctrl, vecs[i].exp_ctrl);
      chk($sformatf("vec%0d_freq", i), freq, vecs[i].exp_freq);
    end

    // Fill, overflow, drain in order
    do_reset();
    wr(7'h01, 32'h1);
    push_words(1, 16);
    read_status("full_status", 32'h00020010);
    samp_valid = 1'b1; samp_data = 32'd17;
    step();
    samp_valid = 1'b0;
    read_status("ovf_status", 32'h00060010);
    bus.addr = 7'h04;
    step();
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("pop%0d_data", i), bus.rdat, 32'(i));
      pop_pulse();
    end
    chk("empty_fifodata", bus.rdat, 32'h0);
    read_status("drained_status", 32'h00050000);

    // Push and pop in the same clk while full; overflow set beats clear
    do_reset();
    wr(7'h01, 32'h1);
    push_words(1, 16);
    bus.addr = 7'h04;
    bus.re = 1'b1;
    step(); step();
    samp_valid = 1'b1; samp_data = 32'd99;
    step();
    samp_valid = 1'b0; bus.re = 1'b0;
    read_status("pushpop_full_status", 32'h00020010);
    bus.addr = 7'h04;
    step();
    chk("pushpop_head", bus.rdat, 32'd2);
    samp_valid = 1'b1; samp_data = 32'd100;
    wr(7'h03, 32'h00040000);
    samp_valid = 1'b0;
    read_status("ovf_beats_clear", 32'h00060010);
    wr(7'h03, 32'h00040000);
    read_status("ovf_cleared", 32'h00020010);

    // Flush with a same-cycle push; pop while empty
    do_reset();
    wr(7'h01, 32'h1);
    push_words(1, 5);
    read_status("five_status", 32'h00000005);
    samp_valid = 1'b1; samp_data = 32'd55;
    wr(7'h01, 32'h3);
    samp_valid = 1'b0;
    read_status("flush_status", 32'h00010000);
    chk("flush_ctrl_out", ctrl, 32'h1);
    bus.addr = 7'h01;
    step();
    chk("flush_ctrl_read", bus.rdat, 32'h1);
    pop_pulse();
    read_status("pop_empty_status", 32'h00010000);

    // Cycle counter
    bus.addr = 7'h05;
    step();
    r1 = bus.rdat;
    repeat (37) step();
    r2 = bus.rdat;
`ifdef RXADC_CYCLE_COUNTER_EN
    chk("cycles_delta", r2 - r1, 32'd37);
`else
    chk("cycles_first", r1, 32'h0);
    chk("cycles_second", r2, 32'h0);
`endif

    // Random run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      sel = $urandom_range(0, 11);
      if (sel <= 4)       a = 7'h04;
      else if (sel == 5)  a = 7'h03;
      else if (sel == 6)  a = 7'h01;
      else if (sel == 7)  a = 7'h02;
      else if (sel == 8)  a = 7'h05;
      else if (sel == 9)  a = 7'h00;
      else                a = 7'($urandom_range(6, 127));
      wd = $urandom();
      if (a == 7'h01) begin
        wd[1] = ($urandom_range(0, 15) == 0);
        wd[0] = ($urandom_range(0, 3) != 0);
      end
      bus.addr   = a;
      bus.wdat   = wd;
      bus.we     = ($urandom_range(0, 7) == 0);
      samp_valid = ($urandom_range(0, 2) == 0);
      samp_data  = $urandom();
      if ($urandom_range(0, 2) == 0) bus.re = ~bus.re;
      step();
      chk("rnd_rdat", bus.rdat, m_rdat);
      chk("rnd_ctrl", ctrl, m_ctrl);
      chk("rnd_freq", freq, m_freq);
    end

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
